reg_file_swap: RTL and testbench
================================

// Module: reg_file_swap
// PURPOSE
//  32x32 register file: two asynchronous read ports, one synchronous write port,
//  and a register-swap command that exchanges the contents of two registers.
//  Serves as the general-purpose register bank of a simple datapath. The swap
//  lets a controller exchange two registers without passing data through the ALU.
// PARAMETERS
//  DATA_WIDTH  32  width of each register and of the data ports
//  ADDR_WIDTH  5   register address width
//  DEPTH       32  number of registers (2**ADDR_WIDTH)
// PORTS
//  clk     in   1           single clock; all state updates on the rising edge
//  rst     in   1           asynchronous, active-low reset
//  A1      in   ADDR_WIDTH  read address, port 1
//  A2      in   ADDR_WIDTH  read address, port 2
//  A3      in   ADDR_WIDTH  write address
//  WE      in   1           write enable for WD3 -> reg[A3]
//  WD3     in   DATA_WIDTH  write data
//  swap    in   1           swap request (rising-edge triggered, see below)
//  Addr_A  in   ADDR_WIDTH  first register of the swap pair
//  Addr_B  in   ADDR_WIDTH  second register of the swap pair
//  RD1     out  DATA_WIDTH  read data, port 1 = reg[A1]
//  RD2     out  DATA_WIDTH  read data, port 2 = reg[A2]
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): all 32 registers clear to 0 and swap_d clears to 0.
//    RD1 and RD2 therefore read 0 while reset is held.
//  - Reads are combinational, with zero latency: RD1=reg[A1], RD2=reg[A2].
//    There is no write-through bypass. A read of reg[A3] shows the old value
//    until the write edge and the new value after it.
//  - Write: on a posedge with WE=1 (and no swap fire), reg[A3] <= WD3.
//  - Every register is writable, including reg[0]. reg[0] is not hardwired to zero.
//  - Swap: an internal flop swap_d samples swap every posedge.
//    - swap_fire = swap & ~swap_d.
//    - On a posedge with swap_fire=1, reg[Addr_A] and reg[Addr_B] exchange
//      contents in that single edge, using values from before the edge.
//    - Holding swap high for N cycles performs exactly one exchange.
//    - Deasserting and reasserting swap performs another exchange.
//  - Addr_A==Addr_B with swap_fire: no register changes.
//  - swap_fire and WE on the same edge: the swap wins and the write is dropped.
//  - Reset asserted during a held swap: swap_d clears. If swap is still high when
//    reset releases, a new exchange fires on the first edge after release.
// TESTING
//  1. Reset: rst=0 -> RD1=RD2=0 for all A1/A2 values; release rst, WE=0 -> reads stay 0.
//  2. Write/readback: for i=0..30, WE=1, A3=i, WD3=i*0x01010101; then A1=A2=i
//     -> RD1=RD2=i*0x01010101, including reg[0]=0.
//  3. Swap: reg0=0xAAAA5555, reg1=0x12345678; Addr_A=0, Addr_B=1, swap held 3 cycles
//     -> reg0=0x12345678, reg1=0xAAAA5555 (one exchange only).
//  4. Repeated swap: pulse swap twice, separated by one low cycle
//     -> both registers return to their original values.
//  5. Conflict: swap rising with WE=1, A3=0, WD3=0xDEADBEEF
//     -> exchange occurs and the write is dropped (reg0 != 0xDEADBEEF).
//  6. Async reset mid-operation: assert rst between clock edges -> RD1/RD2 drop to 0
//     immediately, without waiting for clk.

Source files
------------

// File: rtl/reg_file_swap.sv
// 32x32 general-purpose register bank: two combinational read ports, one write
// port, and an edge-triggered swap that exchanges two registers in a single clock.
module reg_file_swap #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  swap,
  input  logic [ADDR_WIDTH-1:0] Addr_A,
  input  logic [ADDR_WIDTH-1:0] Addr_B,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  swap_d_reg;
  logic                  swap_fire;
  logic [DATA_WIDTH-1:0] swap_a_val;
  logic [DATA_WIDTH-1:0] swap_b_val;

  // Only the first cycle of a held swap request performs an exchange.
  assign swap_fire  = swap & ~swap_d_reg;
  assign swap_a_val = regs[Addr_A];
  assign swap_b_val = regs[Addr_B];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swap_d_reg <= 1'b0;
    end else begin
      swap_d_reg <= swap;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
      logic [DATA_WIDTH-1:0] q_reg;
      logic [DATA_WIDTH-1:0] q_next;

      // A firing swap takes priority and suppresses the write on the same edge.
      always_comb begin
        q_next = q_reg;
        if (swap_fire) begin
          if (Addr_A == IDX) begin
            q_next = swap_b_val;
          end else if (Addr_B == IDX) begin
            q_next = swap_a_val;
          end
        end else if (WE && (A3 == IDX)) begin
          q_next = WD3;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign RD1 = regs[A1];
  assign RD2 = regs[A2];

endmodule

// File: tb/tb_reg_file_swap.sv
// Bench for reg_file_swap: directed scenarios plus random traffic, checked by a
// monitor that pops expected read values pushed by the stimulus.
module tb_reg_file_swap;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A1, A2, A3, Addr_A, Addr_B;
  logic        WE, swap;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  reg_file_swap dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WE(WE), .WD3(WD3),
    .swap(swap), .Addr_A(Addr_A), .Addr_B(Addr_B), .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        exp_q[$];
  logic        chk_now = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: plain register array plus the previous swap level.
  logic [31:0] m [32];
  bit          sd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    sd = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    if (!rst) return;
    if (swap && !sd) begin
      t = m[Addr_A];
      m[Addr_A] = m[Addr_B];
      m[Addr_B] = t;
    end else if (WE) begin
      m[A3] = WD3;
    end
    sd = swap;
  endtask

  task automatic check(input string nm);
    exp_t e;
    e.name = nm;
    e.e1 = m[A1];
    e.e2 = m[A2];
    exp_q.push_back(e);
    #1 chk_now = 1'b1;
    #1 chk_now = 1'b0;
  endtask

  // Check reads with current inputs, then clock one edge through the model.
  task automatic step(input string nm);
    check(nm);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    WE = 0; swap = 0; A3 = 0; WD3 = 0; Addr_A = 0; Addr_B = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge chk_now);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: read strobe with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (RD1 !== e.e1 || RD2 !== e.e2) begin
          errors++;
          $display("FAIL %s: A1=%0d A2=%0d RD1=%h RD2=%h expected %h %h",
                   e.name, A1, A2, RD1, RD2, e.e1, e.e2);
        end else begin
          $display("ok   %s: A1=%0d A2=%0d RD1=%h RD2=%h", e.name, A1, A2, RD1, RD2);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b0;
    idle_inputs();
    A1 = 0; A2 = 0;
    model_reset();

    // Reset held: every address reads zero.
    @(posedge clk); #1;
    for (int i = 0; i < 32; i += 4) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      check("reset_read");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A1 = 5'($urandom_range(0, 31)); A2 = 5'($urandom_range(0, 31));
      step("post_reset");
    end

    // Write/readback including reg[0].
    for (int i = 0; i <= 30; i++) begin
      WE = 1; A3 = 5'(i); WD3 = 32'(i) * 32'h01010101;
      A1 = 5'(i); A2 = 5'(i);
      step("write_old_value");
    end
    WE = 0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i);
      check("readback");
    end

    // Swap held three cycles: one exchange.
    WE = 1; A3 = 0; WD3 = 32'hAAAA5555; step("ld0");
    A3 = 1; WD3 = 32'h12345678; step("ld1");
    WE = 0; A1 = 0; A2 = 1;
    swap = 1; Addr_A = 0; Addr_B = 1;
    for (int i = 0; i < 3; i++) step("swap_held");
    swap = 0; step("swap_done");
    check("swap_result");

    // Two separated pulses restore the originals.
    swap = 1; step("swap_p1"); swap = 0; step("swap_gap");
    swap = 1; step("swap_p2"); swap = 0; step("swap_p2_done");
    check("swap_restore");

    // Swap and write on the same edge: write dropped.
    swap = 1; WE = 1; A3 = 0; WD3 = 32'hDEADBEEF; step("conflict");
    idle_inputs(); A1 = 0; A2 = 1;
    check("conflict_result");

    // Same-address swap leaves the register unchanged.
    Addr_A = 5'd7; Addr_B = 5'd7; swap = 1; A1 = 7; A2 = 7; step("self_swap");
    swap = 0; check("self_swap_result");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      WE = 1'($urandom_range(0, 1));
      A3 = 5'($urandom_range(0, 31));
      WD3 = $urandom;
      if ($urandom_range(0, 3) == 0) swap = ~swap;
      Addr_A = 5'($urandom_range(0, 31));
      Addr_B = ($urandom_range(0, 7) == 0) ? Addr_A : 5'($urandom_range(0, 31));
      A1 = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2 = ($urandom_range(0, 3) == 0) ? Addr_A : 5'($urandom_range(0, 31));
      step("random");
    end

    // Asynchronous reset between edges, with swap still high at release.
    idle_inputs();
    WE = 1; A3 = 2; WD3 = 32'hCAFEF00D; step("pre_rst_ld2");
    A3 = 3; WD3 = 32'h0BADF00D; step("pre_rst_ld3");
    WE = 0; A1 = 2; A2 = 3;
    swap = 1; Addr_A = 2; Addr_B = 3; step("pre_rst_swap");
    check("pre_rst_values");
    #1 rst = 1'b0;
    model_reset();
    check("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    WE = 1; A3 = 2; WD3 = 32'h11112222; step("rel_ld2");
    WE = 0; swap = 0; step("rel_swap_low");
    swap = 1; step("rel_swap_fire");
    swap = 0; check("rel_swap_result");

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected entries unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
